key_search_controller: RTL

//  Initiator side of the key-generator handshake in the RC4 codebreaking datapath.

---
 rtl/key_search_pkg.sv | 25 ++
 rtl/key_search_watchdog.sv | 36 +++
 rtl/key_search_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/key_search_pkg.sv
// ============================================================================
//  Module : key_search_pkg
//  Brief  : Shared state encoding and defaults for the RC4 key search block.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package key_search_pkg;

    localparam int KEY_W_DEF = 24;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_KEY  = 3'd2,
        LAUNCH    = 3'd3,
        WAIT_DEC  = 3'd4,
        CHECK     = 3'd5,
        FOUND     = 3'd6,
        EXHAUSTED = 3'd7
    } ks_state_t;

endpackage

`default_nettype wire

// File: rtl/key_search_watchdog.sv
// ============================================================================
//  Module : key_search_watchdog
//  Brief  : Load/count/expire counter bounding how long one decrypt may take.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_search_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int              CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || load_i) begin
            cnt_q <= '0;
        end else if (count_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th counted cycle.
    assign expired_o = count_i && (cnt_q == C_LAST);

endmodule

`default_nettype wire

// File: rtl/key_search_controller.sv
// ============================================================================
//  Module : key_search_controller
//  Brief  : Requests candidate keys, launches RC4 decrypt, stops on first valid
//           key or when KEY_MAX has been tested. Optional decrypt watchdog is
//           enabled by defining KEY_SEARCH_TIMEOUT_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_search_controller
    import key_search_pkg::*;
#(
    parameter int               KEY_W   = KEY_W_DEF,
    parameter logic [KEY_W-1:0] KEY_MAX = {2'b00, {(KEY_W-2){1'b1}}}
`ifdef KEY_SEARCH_TIMEOUT_EN
    ,
    parameter int               TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             generating_key,
    input  logic             key_generated,
    input  logic [KEY_W-1:0] key_in,
    output logic             decrypt_start,
    output logic [KEY_W-1:0] decrypt_key,
    input  logic             decrypt_done,
    input  logic             decrypt_valid,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] found_key,
    output logic [KEY_W-1:0] attempts
);

    ks_state_t        state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [KEY_W-1:0] fkey_q, fkey_d;
    logic [KEY_W-1:0] att_q, att_d;
    logic             valid_q, valid_d;
    logic             found_q, found_d;
    logic             exh_q, exh_d;
    logic             w_timeout;

`ifdef KEY_SEARCH_TIMEOUT_EN
    key_search_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load_i   (state_q != WAIT_DEC),
        .count_i  (state_q == WAIT_DEC),
        .expired_o(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            fkey_q  <= '0;
            att_q   <= '0;
            valid_q <= 1'b0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            fkey_q  <= fkey_d;
            att_q   <= att_d;
            valid_q <= valid_d;
            found_q <= found_d;
            exh_q   <= exh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        fkey_d  = fkey_q;
        att_d   = att_q;
        valid_d = valid_q;
        found_d = found_q;
        exh_d   = exh_q;
        case (state_q)
            IDLE:     if (start) state_d = REQ;
            REQ:      state_d = WAIT_KEY;
            WAIT_KEY: begin
                if (key_generated) begin
                    key_d   = key_in;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:   state_d = WAIT_DEC;
            WAIT_DEC: begin
                // A real completion wins over a simultaneous watchdog expiry.
                if (decrypt_done || w_timeout) begin
                    valid_d = decrypt_done && decrypt_valid;
                    if (att_q != {KEY_W{1'b1}}) att_d = att_q + 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (valid_q) begin
                    found_d = 1'b1;
                    fkey_d  = key_q;
                    state_d = FOUND;
                end else if (key_q >= KEY_MAX) begin
                    exh_d   = 1'b1;
                    state_d = EXHAUSTED;
                end else begin
                    state_d = REQ;
                end
            end
            FOUND, EXHAUSTED: state_d = state_q;
            default:          state_d = IDLE;
        endcase
    end

    assign generating_key = (state_q == REQ);
    assign decrypt_start  = (state_q == LAUNCH);
    assign busy           = (state_q != IDLE) && (state_q != FOUND) && (state_q != EXHAUSTED);
    assign decrypt_key    = key_q;
    assign found          = found_q;
    assign exhausted      = exh_q;
    assign found_key      = fkey_q;
    assign attempts       = att_q;

endmodule

`default_nettype wire
